hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports i_RsD, i_RtD  input  5 each  source register numbers of the instruction in Decode.
REQ-004 SHALL have ports i_UsesRsD, i_UsesRtD  input  1 each  Decode instruction actually reads Rs/Rt.
REQ-005 SHALL have ports i_RegWriteD, i_MemtoRegD  input  1 each  Decode instruction writes a register / is a load.
REQ-006 SHALL have port i_WriteRegD  input  5  destination register of the Decode instruction, after RegDst selection.
REQ-007 SHALL have port i_JumpD  input  1  taken jump/branch resolved in Decode.
REQ-008 SHALL have ports o_StallF, o_StallD  output  1 each  hold the PC and the Fetch/Decode register.
REQ-009 SHALL have ports o_FlushD, o_FlushE  output  1 each  clear the Fetch/Decode register; drive CLR of the Decode/Execute register.
REQ-010 SHALL have ports o_FwdAE, o_FwdBE  output  2 each  Execute operand source: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-011 SHALL have port o_StallCnt  output  16  saturating count of load-use stall cycles.

Function
REQ-012 SHALL keep a shadow of the E, M and W stages, each entry {RegWrite, MemtoReg, WriteReg, Rs, Rt}, advancing D->E->M->W every cycle.
REQ-013 SHALL load the E entry with all-zero (bubble) when o_FlushE=1, otherwise with the Decode inputs.
REQ-014 SHALL assert load-use hazard LU when E.MemtoReg=1, E.WriteReg!=0 and (i_UsesRsD and i_RsD==E.WriteReg, or i_UsesRtD and i_RtD==E.WriteReg); LU is combinational, same cycle.
REQ-015 SHALL drive o_StallF=o_StallD=o_FlushE=LU.
REQ-016 SHALL drive o_FlushD=i_JumpD and not LU; on a simultaneous jump and load-use, the stall wins and the jump is re-evaluated next cycle.
REQ-017 SHALL set o_FwdAE=10 when M.RegWrite, M.WriteReg!=0 and M.WriteReg==E.Rs; else 01 when the same test holds for W; else 00. o_FwdBE uses E.Rt the same way.
REQ-018 SHALL give Memory-stage forwarding priority over Writeback when both match.
REQ-019 SHALL never forward or stall on register 0.
REQ-020 SHALL derive forwarding only from registered E/M/W state, so outputs settle within the cycle with no combinational path from Decode inputs.
REQ-021 SHALL increment o_StallCnt by 1 in each cycle with LU=1 and hold it at 16'hFFFF once reached.
REQ-022 SHALL limit a single load-use hazard to exactly one stall cycle, because the load has moved to M on the next cycle.

Reset
REQ-023 SHALL, while Reset=1 at a clock edge, clear all E/M/W entries and o_StallCnt to 0.
REQ-024 SHALL output all-zero stall, flush and forward signals in the cycle after reset, since all stage entries are bubbles.
REQ-025 SHALL have reset override every other event in the same cycle, including in-progress stalls and jumps.

Structure
REQ-026 SHALL take the forwarding-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the stage-entry struct width from the shared mips_pkg package.
REQ-027 SHALL implement one sub-module, fwd_sel, instantiated twice (operands A and B), that compares one source against the M and W entries.

Verification
REQ-028 SHALL test: lw $2 in E, Decode add reads $2 -> StallF=StallD=FlushE=1 for exactly 1 cycle, StallCnt 0->1.
REQ-029 SHALL test: add $3 in M and add $3 in W, E reads Rs=$3 -> FwdAE=10 (M priority); when only W matches -> FwdAE=01.
REQ-030 SHALL test: lw $0 in E, Decode reads $0 -> no stall; M.WriteReg=0 with RegWrite=1 -> FwdAE=00.
REQ-031 SHALL test: i_JumpD=1 together with LU=1 -> FlushD=0 and FlushE=1; next cycle with i_JumpD=1 -> FlushD=1.
REQ-032 SHALL test: Reset=1 asserted mid-stall -> next cycle all outputs 0 and StallCnt=0; preload StallCnt to 16'hFFFF, then force a stall -> StallCnt stays 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared pipeline definitions for the MIPS hazard unit.
//   fwd_e    : Execute operand source select (register file / WB / MEM).
//   stage_t  : shadow pipeline entry {RegWrite, MemtoReg, WriteReg, Rs, Rt}.
//   STAGE_W  : width of one stage entry.
//   CNT_MAX  : saturation value of the load-use stall counter.
package mips_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] write_reg;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel -- picks the Execute-stage source for one operand.
//   src : source register number held in the E entry
//   mem : Memory-stage shadow entry
//   wb  : Writeback-stage shadow entry
//   fwd : FWD_MEM / FWD_WB / FWD_RF
// The Memory stage holds the younger producer, so it is checked first.
module fwd_sel
  import mips_pkg::*;
(
  input  logic [4:0] src,
  input  stage_t     mem,
  input  stage_t     wb,
  output logic [1:0] fwd
);

  logic mem_hit, wb_hit;

  // $0 is hard-wired zero: a write to it is never a real producer.
  assign mem_hit = mem.reg_write && (mem.write_reg != 5'd0) && (mem.write_reg == src);
  assign wb_hit  = wb.reg_write  && (wb.write_reg  != 5'd0) && (wb.write_reg  == src);

  always_comb begin
    fwd = FWD_RF;
    if (mem_hit)     fwd = FWD_MEM;
    else if (wb_hit) fwd = FWD_WB;
  end

  // Only the producer fields of M/W matter for forwarding.
  logic unused_bits;
  assign unused_bits = ^{mem.mem_to_reg, mem.rs, mem.rt, wb.mem_to_reg, wb.rs, wb.rt};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- load-use stall, jump flush and operand forwarding control
// for a 5-stage MIPS pipeline. Keeps its own shadow of the E/M/W stages.
//   i_Clk, Reset                  : clock, synchronous active-high reset
//   i_RsD/i_RtD, i_UsesRsD/RtD     : Decode sources and whether they are read
//   i_RegWriteD, i_MemtoRegD,
//   i_WriteRegD                   : Decode destination info (post RegDst)
//   i_JumpD                       : taken jump/branch resolved in Decode
//   o_StallF/o_StallD             : hold PC and F/D register
//   o_FlushD/o_FlushE             : clear F/D register / D/E register
//   o_FwdAE/o_FwdBE               : Execute operand source select
//   o_StallCnt                    : saturating count of load-use stall cycles
module hazard_ctrl
  import mips_pkg::*;
(
  input  logic        i_Clk,
  input  logic        Reset,
  input  logic [4:0]  i_RsD,
  input  logic [4:0]  i_RtD,
  input  logic        i_UsesRsD,
  input  logic        i_UsesRtD,
  input  logic        i_RegWriteD,
  input  logic        i_MemtoRegD,
  input  logic [4:0]  i_WriteRegD,
  input  logic        i_JumpD,
  output logic        o_StallF,
  output logic        o_StallD,
  output logic        o_FlushD,
  output logic        o_FlushE,
  output logic [1:0]  o_FwdAE,
  output logic [1:0]  o_FwdBE,
  output logic [15:0] o_StallCnt
);

  localparam int NUM_OPS = 2;

  stage_t      stg_e, stg_m, stg_w;
  stage_t      dec;
  logic        lu;
  logic [15:0] stall_cnt;

  assign dec = '{reg_write:  i_RegWriteD,
                 mem_to_reg: i_MemtoRegD,
                 write_reg:  i_WriteRegD,
                 rs:         i_RsD,
                 rt:         i_RtD};

  // Load in E whose result a Decode source needs: one bubble is enough since
  // the load reaches M next cycle and becomes forwardable from WB after that.
  assign lu = stg_e.mem_to_reg && (stg_e.write_reg != 5'd0) &&
              ((i_UsesRsD && (i_RsD == stg_e.write_reg)) ||
               (i_UsesRtD && (i_RtD == stg_e.write_reg)));

  assign o_StallF   = lu;
  assign o_StallD   = lu;
  assign o_FlushE   = lu;
  // Stall wins over a jump; the held jump is seen again next cycle.
  assign o_FlushD   = i_JumpD && !lu;
  assign o_StallCnt = stall_cnt;

  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      stg_e     <= '0;
      stg_m     <= '0;
      stg_w     <= '0;
      stall_cnt <= '0;
    end else begin
      stg_w <= stg_m;
      stg_m <= stg_e;
      stg_e <= lu ? stage_t'('0) : dec;
      if (lu && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Forwarding uses registered state only: operand 0 = Rs (A), 1 = Rt (B).
  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] op_fwd;

  assign op_src[0] = stg_e.rs;
  assign op_src[1] = stg_e.rt;

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_sel u_fwd (
        .src (op_src[g]),
        .mem (stg_m),
        .wb  (stg_w),
        .fwd (op_fwd[g])
      );
    end
  endgenerate

  assign o_FwdAE = op_fwd[0];
  assign o_FwdBE = op_fwd[1];

endmodule
